switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter NUM_SW, default 2, giving the number of independent switch channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the consecutive stable cycles needed to accept a new level; legal range 2..2^24.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port sw_raw_i, input, NUM_SW bits: raw pull-up switch levels, 1 = released, 0 = pressed, asynchronous to clk_i.
REQ-006 The block SHALL have port sw_o, output, NUM_SW bits: debounced level, same polarity as sw_raw_i, for direct connection to the up/down counter switch inputs.
REQ-007 The block SHALL have port press_o, output, NUM_SW bits: one-cycle pulse per channel when that channel's sw_o goes 1->0.
REQ-008 The block SHALL have port release_o, output, NUM_SW bits: one-cycle pulse per channel when that channel's sw_o goes 0->1.

Function
REQ-009 Each channel SHALL pass sw_raw_i bit through a two-flop synchronizer; only the second-stage output (sync) drives further logic.
REQ-010 Each channel SHALL hold a stability counter of width clog2(DEBOUNCE_CYCLES+1), unsigned.
REQ-011 When sync equals sw_o, the channel counter SHALL be cleared to 0 on the next edge.
REQ-012 When sync differs from sw_o and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When sync differs from sw_o and the counter equals DEBOUNCE_CYCLES-1, on that edge sw_o SHALL take the value of sync and the counter SHALL clear to 0.
REQ-014 A raw transition held stable SHALL appear on sw_o at the (DEBOUNCE_CYCLES+2)th rising edge after the raw change (2 sync + DEBOUNCE_CYCLES filter).
REQ-015 Any glitch (sync returning to sw_o) before the count completes SHALL clear the counter, leave sw_o unchanged, and produce no pulse.
REQ-016 press_o/release_o SHALL be registered, asserted for exactly one cycle, in the same cycle sw_o first shows the new level.
REQ-017 press_o and release_o of one channel SHALL never be high simultaneously; channels SHALL be fully independent, simultaneous events on different channels allowed.
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 A raw input stuck at the current sw_o level indefinitely SHALL produce no pulses and a counter held at 0.

Reset
REQ-020 While reset_i is high, both synchronizer stages and sw_o SHALL be all-ones (released), counters 0, press_o and release_o 0, taking effect immediately without a clock edge.
REQ-021 Reset asserted mid-count SHALL discard the partial count; after release, a pressed switch SHALL need the full REQ-014 latency before sw_o falls.
REQ-022 Reset deassertion SHALL itself generate no press_o or release_o pulse, whatever sw_raw_i is at that time.

Verification (DEBOUNCE_CYCLES=4, NUM_SW=2)
REQ-023 Reset, sw_raw_i=2'b11 for 20 cycles -> sw_o=2'b11, press_o=release_o=0 throughout.
REQ-024 sw_raw_i[0] 1->0 held -> sw_o[0]=0 at the 6th edge after the change, press_o[0]=1 for that one cycle only; sw_o[1] stays 1.
REQ-025 sw_raw_i[0] low for 3 cycles then back high -> sw_o[0] stays 1, no pulses; then held low 10 cycles -> normal press at edge 6.
REQ-026 Both channels released->pressed on the same cycle, then released after 10 cycles -> press_o=2'b11 on one cycle, later release_o=2'b11 on one cycle.
REQ-027 sw_raw_i[1] pressed, reset_i pulsed at counter=2 while pressed -> outputs return to reset values asynchronously, no pulse at deassertion, sw_o[1]=0 six edges after reset release.

Source files
------------

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer for active-low pull-up switches.
// Each channel synchronizes its raw input, then only accepts a new level once the
// synchronized value has differed from the debounced level for DEBOUNCE_CYCLES
// consecutive clocks. Press/release pulses are registered and line up with the
// cycle in which sw_o first shows the new level.
module switch_debounce #(
  parameter int unsigned NUM_SW          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic [NUM_SW-1:0] sw_o,
  output logic [NUM_SW-1:0] press_o,
  output logic [NUM_SW-1:0] release_o
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] sw_q, sw_d;
  logic [NUM_SW-1:0] press_q, press_d;
  logic [NUM_SW-1:0] release_q, release_d;
  logic [CntW-1:0]   cnt_q [NUM_SW];
  logic [CntW-1:0]   cnt_d [NUM_SW];

  // Per-channel stability counting; a level is accepted on the edge the count completes.
  always_comb begin
    sw_d      = sw_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          sw_d[i]      = sync2_q[i];
          // 1->0 is a press, 0->1 a release; the count restarts from 0.
          press_d[i]   = ~sync2_q[i];
          release_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // State registers; reset forces every channel to the released level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      sw_q      <= '1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sw_raw_i;
      sync2_q   <= sync1_q;
      sw_q      <= sw_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_o      = sw_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios with literal expectations plus
// randomized raw switch activity checked every cycle against a sliding-window model.
module tb_switch_debounce;

  localparam int unsigned NS = 2;
  localparam int unsigned DC = 4;

  logic          clk;
  logic          reset_i;
  logic [NS-1:0] sw_raw_i;
  logic [NS-1:0] sw_o, press_o, release_o;

  int vectors     = 0;
  int miscompares = 0;

  switch_debounce #(
    .NUM_SW         (NS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .sw_raw_i (sw_raw_i),
    .sw_o     (sw_o),
    .press_o  (press_o),
    .release_o(release_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: raw levels reach the filter two edges late; a channel flips once the
  // last DC filter samples all disagree with its current debounced level.
  bit            rh0 [NS];
  bit            rh1 [NS];
  bit            win [NS][DC];
  int            nvalid [NS];
  logic [NS-1:0] exp_sw, exp_press, exp_rel;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      rh0[i]    = 1'b1;
      rh1[i]    = 1'b1;
      nvalid[i] = 0;
      for (int j = 0; j < DC; j++) win[i][j] = 1'b1;
    end
    exp_sw    = '1;
    exp_press = '0;
    exp_rel   = '0;
  endtask

  task automatic model_step();
    bit s;
    bit upd;
    for (int i = 0; i < NS; i++) begin
      s      = rh1[i];
      rh1[i] = rh0[i];
      rh0[i] = sw_raw_i[i];
      for (int j = DC - 1; j > 0; j--) win[i][j] = win[i][j-1];
      win[i][0] = s;
      if (nvalid[i] < DC) nvalid[i]++;
      upd = (nvalid[i] >= DC);
      for (int j = 0; j < DC; j++) begin
        if (win[i][j] == exp_sw[i]) upd = 1'b0;
      end
      exp_press[i] = upd && exp_sw[i];
      exp_rel[i]   = upd && !exp_sw[i];
      if (upd) exp_sw[i] = s;
    end
  endtask

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    vectors++;
    if (sw_o !== exp_sw || press_o !== exp_press || release_o !== exp_rel) begin
      miscompares++;
      $display("FAIL model t=%0t sw_o=%b want %b press_o=%b want %b release_o=%b want %b",
               $time, sw_o, exp_sw, press_o, exp_press, release_o, exp_rel);
    end
  end

  task automatic check(input string name, input logic [NS-1:0] got,
                       input logic [NS-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int run [NS];

  initial begin
    sw_raw_i = '1;
    reset_i  = 1'b0;
    #1 reset_i = 1'b1;
    #2;
    // Reset must act without any clock edge.
    check("rst_sw", sw_o, 2'b11);
    check("rst_press", press_o, 2'b00);
    check("rst_release", release_o, 2'b00);
    @(negedge clk);
    #2 reset_i = 1'b0;

    // Idle released for 20 cycles.
    repeat (20) @(negedge clk);
    check("idle_sw", sw_o, 2'b11);

    // Channel 0 press: new level on the 6th edge, one-cycle pulse.
    sw_raw_i = 2'b10;
    after_edges(5);
    check("press0_edge5_sw", sw_o, 2'b11);
    after_edges(1);
    check("press0_edge6_sw", sw_o, 2'b10);
    check("press0_edge6_press", press_o, 2'b01);
    after_edges(1);
    check("press0_edge7_press", press_o, 2'b00);
    @(negedge clk);
    sw_raw_i = 2'b11;
    after_edges(6);
    check("release0_sw", sw_o, 2'b11);
    check("release0_pulse", release_o, 2'b01);
    repeat (4) @(negedge clk);

    // Three-cycle glitch is rejected, then a held press is accepted.
    sw_raw_i = 2'b10;
    repeat (3) @(negedge clk);
    sw_raw_i = 2'b11;
    repeat (10) @(negedge clk);
    check("glitch_sw", sw_o, 2'b11);
    sw_raw_i = 2'b10;
    after_edges(6);
    check("after_glitch_sw", sw_o, 2'b10);
    check("after_glitch_press", press_o, 2'b01);
    repeat (4) @(negedge clk);
    sw_raw_i = 2'b11;
    repeat (10) @(negedge clk);

    // Both channels together.
    sw_raw_i = 2'b00;
    after_edges(6);
    check("both_press", press_o, 2'b11);
    check("both_press_sw", sw_o, 2'b00);
    repeat (4) @(negedge clk);
    sw_raw_i = 2'b11;
    after_edges(6);
    check("both_release", release_o, 2'b11);
    check("both_release_sw", sw_o, 2'b11);
    repeat (4) @(negedge clk);

    // Reset mid-count on channel 1; full latency needed afterwards.
    sw_raw_i = 2'b01;
    after_edges(4);
    #1 reset_i = 1'b1;
    #1;
    check("midrst_sw", sw_o, 2'b11);
    @(negedge clk);
    #2 reset_i = 1'b0;
    after_edges(1);
    check("rst_release_nopulse", press_o | release_o, 2'b00);
    after_edges(4);
    check("midrst_edge5_sw", sw_o, 2'b11);
    after_edges(1);
    check("midrst_edge6_sw", sw_o, 2'b01);
    check("midrst_edge6_press", press_o, 2'b10);
    @(negedge clk);
    sw_raw_i = 2'b11;
    repeat (10) @(negedge clk);

    // Randomized bouncing with occasional asynchronous resets.
    for (int i = 0; i < NS; i++) run[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (run[i] == 0) begin
          sw_raw_i[i] = 1'($urandom_range(0, 1));
          run[i] = $urandom_range(1, 8);
        end
        run[i]--;
      end
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #3 reset_i = 1'b1;
        @(negedge clk);
        #2 reset_i = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
